// File: rtl/nlynx_pkg.sv
// Shared constants and types for the snapshot FIFO.
// Provides the default sizes, the header field layout and small counter types.
package nlynx_pkg;

  localparam int unsigned NLYNX_METRICS       = 13;
  localparam int unsigned NLYNX_COUNTER_WIDTH = 32;
  localparam int unsigned NLYNX_SNAP_DEPTH    = 4;
  localparam int unsigned NLYNX_SEQ_WIDTH     = 8;
  localparam int unsigned NLYNX_DROP_WIDTH    = 16;
  localparam int unsigned NLYNX_HDR_OVF_LSB   = 0;

  typedef logic [NLYNX_SEQ_WIDTH-1:0]  nlynx_seq_t;
  typedef logic [NLYNX_DROP_WIDTH-1:0] nlynx_drop_t;

  // The sequence field sits directly above the per-metric overflow flags.
  function automatic int unsigned nlynx_hdr_seq_lsb(input int unsigned num_metrics);
    return NLYNX_HDR_OVF_LSB + num_metrics;
  endfunction

  localparam int unsigned NLYNX_HDR_SEQ_LSB = nlynx_hdr_seq_lsb(NLYNX_METRICS);

endpackage

// File: rtl/nlynx_snapshot_mem.sv
// Snapshot storage: writes a whole snapshot in one cycle, reads one word.
// Contents are not reset; validity is tracked by the FIFO control.
module nlynx_snapshot_mem
  import nlynx_pkg::*;
#(
  parameter int unsigned NUM_METRICS = NLYNX_METRICS,
  parameter int unsigned CNT_WIDTH   = NLYNX_COUNTER_WIDTH,
  parameter int unsigned DEPTH       = NLYNX_SNAP_DEPTH,
  parameter int unsigned WORDS       = NUM_METRICS + 1,
  parameter int unsigned PTR_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int unsigned IDX_W       = $clog2(WORDS)
) (
  input  logic                       clk_i,
  input  logic                       wr_en_i,
  input  logic [PTR_W-1:0]           wr_ptr_i,
  input  logic [WORDS*CNT_WIDTH-1:0] wr_data_i,
  input  logic [PTR_W-1:0]           rd_ptr_i,
  input  logic [IDX_W-1:0]           rd_idx_i,
  output logic [CNT_WIDTH-1:0]       rd_data_c
);

  logic [CNT_WIDTH-1:0] mem_q [DEPTH][WORDS];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      for (int unsigned w = 0; w < WORDS; w++) begin
        mem_q[wr_ptr_i][w] <= wr_data_i[w*CNT_WIDTH +: CNT_WIDTH];
      end
    end
  end

  assign rd_data_c = mem_q[rd_ptr_i][rd_idx_i];

endmodule

// File: rtl/nlynx_snapshot_fifo.sv
// Captures counter snapshots on eop_i rising edges and streams them out
// word by word (header first) through a valid/ready interface.
module nlynx_snapshot_fifo
  import nlynx_pkg::*;
#(
  parameter int unsigned NUM_METRICS = NLYNX_METRICS,
  parameter int unsigned CNT_WIDTH   = NLYNX_COUNTER_WIDTH,
  parameter int unsigned DEPTH       = NLYNX_SNAP_DEPTH
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NUM_METRICS*CNT_WIDTH-1:0] cnt_i,
  input  logic [NUM_METRICS-1:0]           overflow_i,
  input  logic                             eop_i,
  input  logic                             clear_i,
  output logic [CNT_WIDTH-1:0]             out_data_o,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic                             out_last_o,
  output logic [15:0]                      drop_cnt_o,
  output logic                             full_o,
  output logic                             empty_o
);

  localparam int unsigned WORDS   = NUM_METRICS + 1;
  localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W   = $clog2(WORDS);
  localparam int unsigned SEQ_LSB = nlynx_hdr_seq_lsb(NUM_METRICS);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_METRICS);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);

  logic                 eop_q, eop_d;
  nlynx_seq_t           seq_q, seq_d;
  nlynx_drop_t          drop_q, drop_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_last_q, out_last_d;
  logic [CNT_WIDTH-1:0] out_data_q, out_data_d;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;

  logic                 hs_c, last_hs_c, trig_c, full_c, wr_en_c, bypass_c;
  logic [CNT_WIDTH-1:0] hdr_c, mem_rd_c, rd_word_c;
  logic [WORDS-1:0][CNT_WIDTH-1:0] snap_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign hdr_c  = (CNT_WIDTH'(overflow_i) << NLYNX_HDR_OVF_LSB)
                | (CNT_WIDTH'(seq_q) << SEQ_LSB);
  assign snap_c = {cnt_i, hdr_c};

  nlynx_snapshot_mem #(
    .NUM_METRICS (NUM_METRICS),
    .CNT_WIDTH   (CNT_WIDTH),
    .DEPTH       (DEPTH),
    .WORDS       (WORDS),
    .PTR_W       (PTR_W),
    .IDX_W       (IDX_W)
  ) u_mem (
    .clk_i     (clk_i),
    .wr_en_i   (wr_en_c),
    .wr_ptr_i  (wr_ptr_q),
    .wr_data_i (snap_c),
    .rd_ptr_i  (rd_ptr_d),
    .rd_idx_i  (idx_d),
    .rd_data_c (mem_rd_c)
  );

  // Capture, drop and read-pointer control.
  always_comb begin
    eop_d     = eop_i;
    seq_d     = seq_q;
    drop_d    = drop_q;
    count_d   = count_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    idx_d     = idx_q;
    wr_en_c   = 1'b0;
    hs_c      = out_valid_q && out_ready_i;
    last_hs_c = hs_c && (idx_q == LAST_IDX);
    trig_c    = eop_i && !eop_q;
    full_c    = (count_q == FULL_CNT);

    if (clear_i) begin
      seq_d    = '0;
      drop_d   = '0;
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      idx_d    = '0;
    end else begin
      if (hs_c) begin
        if (last_hs_c) begin
          idx_d    = '0;
          rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      // A slot freed by the final-word handshake this cycle is reusable at once.
      if (trig_c) begin
        if (!full_c || last_hs_c) begin
          wr_en_c  = 1'b1;
          wr_ptr_d = ptr_inc(wr_ptr_q);
          seq_d    = seq_q + NLYNX_SEQ_WIDTH'(1);
        end else if (drop_q != '1) begin
          drop_d = drop_q + NLYNX_DROP_WIDTH'(1);
        end
      end
      count_d = count_q + CNT_W'(wr_en_c) - CNT_W'(last_hs_c);
    end
  end

  // Next output word; bypass storage when the snapshot being written is next to show.
  always_comb begin
    bypass_c    = wr_en_c && (rd_ptr_d == wr_ptr_q);
    rd_word_c   = bypass_c ? snap_c[idx_d] : mem_rd_c;
    out_valid_d = (count_d != '0);
    out_last_d  = out_valid_d && (idx_d == LAST_IDX);
    out_data_d  = out_valid_d ? rd_word_c : '0;
    full_d      = (count_d == FULL_CNT);
    empty_d     = (count_d == '0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      eop_q       <= 1'b0;
      seq_q       <= '0;
      drop_q      <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
    end else begin
      eop_q       <= eop_d;
      seq_q       <= seq_d;
      drop_q      <= drop_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
    end
  end

  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign out_last_o  = out_last_q;
  assign drop_cnt_o  = drop_q;
  assign full_o      = full_q;
  assign empty_o     = empty_q;

endmodule

// File: tb/tb_nlynx_snapshot_fifo.sv
// Self-checking bench for nlynx_snapshot_fifo using a word-level scoreboard
// and a small transaction model of capture, drop and clear behaviour.
module tb_nlynx_snapshot_fifo;

  localparam int NM      = 13;
  localparam int CW      = 32;
  localparam int DEPTH   = 4;
  localparam int SEQ_LSB = NM;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b1;
  logic [NM*CW-1:0]  cnt_i = '0;
  logic [NM-1:0]     overflow_i = '0;
  logic              eop_i = 1'b0;
  logic              clear_i = 1'b0;
  logic [CW-1:0]     out_data_o;
  logic              out_valid_o;
  logic              out_ready_i = 1'b0;
  logic              out_last_o;
  logic [15:0]       drop_cnt_o;
  logic              full_o;
  logic              empty_o;

  int          checks = 0;
  int          failures = 0;
  int          m_count;
  logic [7:0]  m_seq;
  logic [15:0] m_drop;
  logic        m_eop_q;
  logic [CW:0] exp_q[$];

  nlynx_snapshot_fifo #(.NUM_METRICS(NM), .CNT_WIDTH(CW), .DEPTH(DEPTH)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .cnt_i       (cnt_i),
    .overflow_i  (overflow_i),
    .eop_i       (eop_i),
    .clear_i     (clear_i),
    .out_data_o  (out_data_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_last_o  (out_last_o),
    .drop_cnt_o  (drop_cnt_o),
    .full_o      (full_o),
    .empty_o     (empty_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    exp_q.delete();
    m_count = 0;
    m_seq   = '0;
    m_drop  = '0;
    m_eop_q = 1'b0;
  endtask

  task automatic set_counters(input int base);
    for (int k = 0; k < NM; k++) cnt_i[k*CW +: CW] = CW'(base + k);
  endtask

  task automatic set_random_counters();
    for (int k = 0; k < NM; k++) cnt_i[k*CW +: CW] = $urandom;
    overflow_i = NM'($urandom);
  endtask

  // Drives one cycle of stimulus, updates the model for the coming edge, then
  // advances to 1 time unit after that edge.
  task automatic drive_cycle(input logic eop, input logic rdy, input logic clr);
    logic hs, last_hs, trig, full;
    eop_i       = eop;
    out_ready_i = rdy;
    clear_i     = clr;
    hs      = (m_count != 0) && rdy;
    last_hs = 1'b0;
    if (hs) last_hs = exp_q[0][CW];
    trig = eop && !m_eop_q;
    full = (m_count == DEPTH);
    if (clr) begin
      exp_q.delete();
      m_count = 0;
      m_seq   = '0;
      m_drop  = '0;
    end else begin
      if (hs) begin
        void'(exp_q.pop_front());
        if (last_hs) m_count--;
      end
      if (trig) begin
        if (!full || last_hs) begin
          exp_q.push_back({1'b0, CW'(overflow_i) | (CW'(m_seq) << SEQ_LSB)});
          for (int k = 0; k < NM; k++) exp_q.push_back({(k == NM - 1), cnt_i[k*CW +: CW]});
          m_count++;
          m_seq++;
        end else if (m_drop != 16'hFFFF) begin
          m_drop++;
        end
      end
    end
    m_eop_q = eop;
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_reset();
    rst_ni = 1'b0;
    eop_i = 1'b0;
    clear_i = 1'b0;
    out_ready_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    #1 rst_ni = 1'b0;
    #1;
    checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", out_valid_o); end
    checks++; if (out_last_o !== 1'b0) begin failures++; $display("FAIL reset_last: got %b want 0", out_last_o); end
    checks++; if (out_data_o !== '0) begin failures++; $display("FAIL reset_data: got %h want 0", out_data_o); end
    checks++; if (drop_cnt_o !== 16'd0) begin failures++; $display("FAIL reset_drop: got %0d want 0", drop_cnt_o); end
    checks++; if (empty_o !== 1'b1 || full_o !== 1'b0) begin failures++; $display("FAIL reset_status: got empty=%b full=%b want 1/0", empty_o, full_o); end
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    model_reset();
    drive_cycle(1'b0, 1'b1, 1'b0);
    checks++; if (out_valid_o !== 1'b0 || empty_o !== 1'b1) begin failures++; $display("FAIL idle_after_reset: got valid=%b empty=%b want 0/1", out_valid_o, empty_o); end
  endtask

  task automatic test_basic_stream();
    apply_reset();
    set_counters(100);
    overflow_i = '0;
    drive_cycle(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < NM + 1; i++) begin
      checks++;
      if (out_valid_o !== 1'b1 || out_data_o !== ((i == 0) ? CW'(0) : CW'(99 + i)) || out_last_o !== (i == NM)) begin
        failures++;
        $display("FAIL basic_word%0d: got v=%b d=%0d l=%b want v=1 d=%0d l=%b", i, out_valid_o, out_data_o, out_last_o, (i == 0) ? 0 : 99 + i, (i == NM));
      end
      checks++; if (out_data_o !== exp_q[0][CW-1:0]) begin failures++; $display("FAIL basic_sb%0d: got %h want %h", i, out_data_o, exp_q[0][CW-1:0]); end
      drive_cycle(1'b0, 1'b1, 1'b0);
    end
    checks++; if (out_valid_o !== 1'b0 || empty_o !== 1'b1) begin failures++; $display("FAIL basic_end: got valid=%b empty=%b want 0/1", out_valid_o, empty_o); end
  endtask

  task automatic test_full_drop();
    apply_reset();
    overflow_i = '0;
    for (int s = 0; s < 5; s++) begin
      set_counters(1000 * (s + 1));
      drive_cycle(1'b1, 1'b0, 1'b0);
      drive_cycle(1'b0, 1'b0, 1'b0);
    end
    checks++; if (full_o !== 1'b1 || empty_o !== 1'b0) begin failures++; $display("FAIL fill_status: got full=%b empty=%b want 1/0", full_o, empty_o); end
    checks++; if (drop_cnt_o !== 16'd1) begin failures++; $display("FAIL fill_drop: got %0d want 1", drop_cnt_o); end
    for (int s = 0; s < 4; s++) begin
      for (int w = 0; w < NM + 1; w++) begin
        checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== exp_q[0][CW-1:0] || out_last_o !== exp_q[0][CW]) begin
          failures++;
          $display("FAIL drain_s%0d_w%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b", s, w, out_valid_o, out_data_o, out_last_o, exp_q[0][CW-1:0], exp_q[0][CW]);
        end
        if (w == 0) begin
          checks++; if (out_data_o !== (CW'(s) << SEQ_LSB)) begin failures++; $display("FAIL drain_seq%0d: got %h want %h", s, out_data_o, CW'(s) << SEQ_LSB); end
        end
        drive_cycle(1'b0, 1'b1, 1'b0);
      end
    end
    checks++; if (empty_o !== 1'b1 || out_valid_o !== 1'b0) begin failures++; $display("FAIL drain_end: got empty=%b valid=%b want 1/0", empty_o, out_valid_o); end
  endtask

  task automatic test_full_coincident();
    int n;
    apply_reset();
    overflow_i = '0;
    for (int s = 0; s < 4; s++) begin
      set_counters(2000 + 50 * s);
      drive_cycle(1'b1, 1'b0, 1'b0);
      drive_cycle(1'b0, 1'b0, 1'b0);
    end
    for (int w = 0; w < NM; w++) drive_cycle(1'b0, 1'b1, 1'b0);
    checks++; if (out_last_o !== 1'b1 || full_o !== 1'b1) begin failures++; $display("FAIL coinc_pre: got last=%b full=%b want 1/1", out_last_o, full_o); end
    set_counters(3000);
    drive_cycle(1'b1, 1'b1, 1'b0);
    checks++; if (drop_cnt_o !== 16'd0) begin failures++; $display("FAIL coinc_drop: got %0d want 0", drop_cnt_o); end
    checks++; if (full_o !== 1'b1) begin failures++; $display("FAIL coinc_full: got %b want 1", full_o); end
    checks++; if (out_data_o !== (CW'(1) << SEQ_LSB)) begin failures++; $display("FAIL coinc_next_hdr: got %h want %h", out_data_o, CW'(1) << SEQ_LSB); end
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (out_valid_o !== 1'b1 || out_data_o !== exp_q[0][CW-1:0] || out_last_o !== exp_q[0][CW]) begin
        failures++;
        $display("FAIL coinc_drain%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b", i, out_valid_o, out_data_o, out_last_o, exp_q[0][CW-1:0], exp_q[0][CW]);
      end
      drive_cycle(1'b0, 1'b1, 1'b0);
    end
    checks++; if (n != 4 * (NM + 1) || out_valid_o !== 1'b0) begin failures++; $display("FAIL coinc_total: got words=%0d valid=%b want %0d/0", n, out_valid_o, 4 * (NM + 1)); end
  endtask

  task automatic test_random_stall();
    int n;
    apply_reset();
    for (int c = 0; c < 800; c++) begin
      checks++; if (out_valid_o !== (m_count != 0)) begin failures++; $display("FAIL rnd_valid c%0d: got %b want %b", c, out_valid_o, (m_count != 0)); end
      if (m_count != 0) begin
        checks++;
        if (out_data_o !== exp_q[0][CW-1:0] || out_last_o !== exp_q[0][CW]) begin
          failures++;
          $display("FAIL rnd_word c%0d: got d=%h l=%b want d=%h l=%b", c, out_data_o, out_last_o, exp_q[0][CW-1:0], exp_q[0][CW]);
        end
      end
      checks++; if (full_o !== (m_count == DEPTH) || empty_o !== (m_count == 0)) begin failures++; $display("FAIL rnd_status c%0d: got full=%b empty=%b count=%0d", c, full_o, empty_o, m_count); end
      set_random_counters();
      drive_cycle(($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1, 1'b0);
    end
    checks++; if (drop_cnt_o !== m_drop) begin failures++; $display("FAIL rnd_drop: got %0d want %0d", drop_cnt_o, m_drop); end
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (out_valid_o !== 1'b1 || out_data_o !== exp_q[0][CW-1:0] || out_last_o !== exp_q[0][CW]) begin
        failures++;
        $display("FAIL rnd_drain%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b", i, out_valid_o, out_data_o, out_last_o, exp_q[0][CW-1:0], exp_q[0][CW]);
      end
      drive_cycle(1'b0, 1'b1, 1'b0);
    end
    checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL rnd_end: got valid=%b want 0", out_valid_o); end
  endtask

  task automatic test_clear();
    int n;
    apply_reset();
    overflow_i = 13'h0F0;
    for (int s = 0; s < 5; s++) begin
      set_counters(4000 + s);
      drive_cycle(1'b1, 1'b0, 1'b0);
      drive_cycle(1'b0, 1'b0, 1'b0);
    end
    for (int w = 0; w < 2 * (NM + 1); w++) drive_cycle(1'b0, 1'b1, 1'b0);
    checks++; if (drop_cnt_o !== 16'd1 || empty_o !== 1'b0 || full_o !== 1'b0) begin failures++; $display("FAIL clr_pre: got drop=%0d empty=%b full=%b want 1/0/0", drop_cnt_o, empty_o, full_o); end
    drive_cycle(1'b1, 1'b0, 1'b1);
    checks++; if (empty_o !== 1'b1 || out_valid_o !== 1'b0 || full_o !== 1'b0) begin failures++; $display("FAIL clr_empty: got empty=%b valid=%b full=%b want 1/0/0", empty_o, out_valid_o, full_o); end
    checks++; if (drop_cnt_o !== 16'd0) begin failures++; $display("FAIL clr_drop: got %0d want 0", drop_cnt_o); end
    drive_cycle(1'b0, 1'b0, 1'b0);
    checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL clr_no_capture: got valid=%b want 0", out_valid_o); end
    overflow_i = 13'h155;
    set_counters(5000);
    drive_cycle(1'b1, 1'b1, 1'b0);
    checks++; if (out_valid_o !== 1'b1 || out_data_o !== CW'(13'h155)) begin failures++; $display("FAIL clr_hdr: got v=%b d=%h want v=1 d=%h", out_valid_o, out_data_o, CW'(13'h155)); end
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (out_data_o !== exp_q[0][CW-1:0] || out_last_o !== exp_q[0][CW]) begin
        failures++;
        $display("FAIL clr_drain%0d: got d=%h l=%b want d=%h l=%b", i, out_data_o, out_last_o, exp_q[0][CW-1:0], exp_q[0][CW]);
      end
      drive_cycle(1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_reset_midstream();
    int n;
    apply_reset();
    overflow_i = '0;
    set_counters(600);
    drive_cycle(1'b1, 1'b1, 1'b0);
    for (int w = 0; w < 6; w++) drive_cycle(1'b0, 1'b1, 1'b0);
    checks++; if (out_valid_o !== 1'b1 || out_data_o !== CW'(605)) begin failures++; $display("FAIL mid_word7: got v=%b d=%0d want v=1 d=605", out_valid_o, out_data_o); end
    eop_i = 1'b1;
    #2 rst_ni = 1'b0;
    #1;
    checks++; if (out_valid_o !== 1'b0 || out_data_o !== '0) begin failures++; $display("FAIL mid_async: got v=%b d=%h want 0/0", out_valid_o, out_data_o); end
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    model_reset();
    checks++; if (empty_o !== 1'b1 || out_valid_o !== 1'b0) begin failures++; $display("FAIL mid_release: got empty=%b valid=%b want 1/0", empty_o, out_valid_o); end
    overflow_i = 13'h1A5;
    set_counters(700);
    drive_cycle(1'b1, 1'b1, 1'b0);
    checks++; if (out_valid_o !== 1'b1 || out_data_o !== CW'(13'h1A5)) begin failures++; $display("FAIL held_eop_capture: got v=%b d=%h want v=1 d=%h", out_valid_o, out_data_o, CW'(13'h1A5)); end
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (out_data_o !== exp_q[0][CW-1:0] || out_last_o !== exp_q[0][CW]) begin
        failures++;
        $display("FAIL held_drain%0d: got d=%h l=%b want d=%h l=%b", i, out_data_o, out_last_o, exp_q[0][CW-1:0], exp_q[0][CW]);
      end
      drive_cycle(1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    int first, last, words;
    apply_reset();
    first = -1;
    last  = -1;
    words = 0;
    for (int c = 0; c < 60; c++) begin
      if (m_count != 0) begin
        checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== exp_q[0][CW-1:0] || out_last_o !== exp_q[0][CW]) begin
          failures++;
          $display("FAIL b2b_c%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b", c, out_valid_o, out_data_o, out_last_o, exp_q[0][CW-1:0], exp_q[0][CW]);
        end
      end
      if (out_valid_o === 1'b1) begin
        if (first < 0) first = c;
        last = c;
        words++;
      end
      set_random_counters();
      drive_cycle((c < 6) && (c % 2 == 0), 1'b1, 1'b0);
    end
    checks++; if (words != 3 * (NM + 1) || (last - first + 1) != 3 * (NM + 1)) begin failures++; $display("FAIL b2b_bubble: got words=%0d span=%0d want %0d", words, last - first + 1, 3 * (NM + 1)); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic_stream();
    test_full_drop();
    test_full_coincident();
    test_random_stall();
    test_clear();
    test_reset_midstream();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
